// File: rtl/alu_mul_queue.sv
// Bus-slave ALU with queued commands, a WIDTH-cycle shift-add multiplier and a result FIFO.
// Optional macro ALU_MUL_SIGNED_EN turns opcode 0xD into a signed multiply.
module alu_mul_queue #(
    parameter int WIDTH      = 32,
    parameter int INST_DEPTH = 4,
    parameter int RES_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             S_sel,
    input  logic             S_wr,
    input  logic [7:0]       S_addr,
    input  logic [WIDTH-1:0] S_din,
    output logic [WIDTH-1:0] S_dout,
    output logic             m_interrupt
);
    localparam int SHW = $clog2(WIDTH);
    localparam int IPW = $clog2(INST_DEPTH);
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int CW  = SHW + 1;
    localparam int IW  = 2 * WIDTH + 4;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [3:0]         opc_q, opc_d;
    logic               intr_en_q, intr_en_d;
    logic               ovf_q, ovf_d, udf_q, udf_d, bad_q, bad_d;
    logic               irq_q, irq_d;

    logic [IW-1:0]      inst_mem [INST_DEPTH];
    logic [IPW-1:0]     inst_wp_q, inst_wp_d, inst_rp_q, inst_rp_d;
    logic [IPW:0]       inst_cnt_q, inst_cnt_d;

    logic [2*WIDTH-1:0] res_mem [RES_DEPTH];
    logic [RPW-1:0]     res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [RPW:0]       res_cnt_q, res_cnt_d;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   wa_q, wa_d, wb_q, wb_d;
    logic [3:0]         wop_q, wop_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`ifdef ALU_MUL_SIGNED_EN
    logic               neg_q, neg_d;
`endif

    logic wr_en, rd_en, clear, wr_push, wr_pop;
    logic inst_full, inst_empty, res_full, res_empty;
    logic ctrl_pop, push_ok, push_ovf, res_push, bus_pop, pop_udf, bad_set;
    logic [2*WIDTH-1:0] alu_res, mul_next, res_val;
    logic               alu_bad;
    logic [WIDTH:0]     mul_sum;
    logic [SHW-1:0]     sh;
    logic [7:0]         status;

    assign wr_en   = S_sel & S_wr;
    assign rd_en   = S_sel & ~S_wr;
    assign clear   = wr_en && (S_addr == 8'h08) && S_din[0];
    assign wr_push = wr_en && (S_addr == 8'h03);
    assign wr_pop  = wr_en && (S_addr == 8'h06);

    assign inst_full  = (inst_cnt_q == (IPW+1)'(INST_DEPTH));
    assign inst_empty = (inst_cnt_q == '0);
    assign res_full   = (res_cnt_q == (RPW+1)'(RES_DEPTH));
    assign res_empty  = (res_cnt_q == '0);

    // A full queue still accepts a push when the controller frees a slot on the same edge.
    assign ctrl_pop = (state_q == IDLE) && !inst_empty && !res_full && !clear;
    assign push_ok  = wr_push && !clear && (!inst_full || ctrl_pop);
    assign push_ovf = wr_push && !clear && inst_full && !ctrl_pop;
    assign res_push = (state_q == DONE) && !clear;
    assign bus_pop  = wr_pop && !clear && !res_empty;
    assign pop_udf  = wr_pop && !clear && res_empty;

`ifdef ALU_MUL_SIGNED_EN
    assign res_val = neg_q ? (~prod_q + 1'b1) : prod_q;
`else
    assign res_val = prod_q;
`endif

    // One shift-add step: conditionally add the multiplicand into the upper half, shift right.
    assign mul_sum  = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, wa_q})
                                : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        sh      = wb_q[SHW-1:0];
        case (wop_q)
            4'h0: alu_res = '0;
            4'h1: alu_res[WIDTH-1:0] = ~wa_q;
            4'h2: alu_res[WIDTH-1:0] = ~wb_q;
            4'h3: alu_res[WIDTH-1:0] = wa_q & wb_q;
            4'h4: alu_res[WIDTH-1:0] = wa_q | wb_q;
            4'h5: alu_res[WIDTH-1:0] = wa_q ^ wb_q;
            4'h6: alu_res[WIDTH-1:0] = ~(wa_q ^ wb_q);
            4'h7: alu_res[WIDTH-1:0] = wa_q << sh;
            4'h8: alu_res[WIDTH-1:0] = wa_q >> sh;
            4'h9: alu_res[WIDTH-1:0] = $unsigned($signed(wa_q) >>> sh);
            4'hA: alu_res[WIDTH:0]   = {1'b0, wa_q} + {1'b0, wb_q};
            4'hB: begin
                alu_res[WIDTH-1:0] = wa_q - wb_q;
                alu_res[WIDTH]     = (wa_q < wb_q);
            end
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        wop_d   = wop_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        bad_set = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_pop) begin
                    {wa_d, wb_d, wop_d} = inst_mem[inst_rp_q];
                    state_d = EXEC;
                end
            end
            EXEC: begin
`ifdef ALU_MUL_SIGNED_EN
                neg_d = 1'b0;
`endif
                if (wop_q == 4'hC) begin
                    prod_d  = {{WIDTH{1'b0}}, wb_q};
                    cnt_d   = CW'(WIDTH);
                    state_d = MUL;
`ifdef ALU_MUL_SIGNED_EN
                end else if (wop_q == 4'hD) begin
                    // Multiply magnitudes; the sign is applied when the result is stored.
                    wa_d    = wa_q[WIDTH-1] ? (~wa_q + 1'b1) : wa_q;
                    prod_d  = {{WIDTH{1'b0}}, (wb_q[WIDTH-1] ? (~wb_q + 1'b1) : wb_q)};
                    neg_d   = wa_q[WIDTH-1] ^ wb_q[WIDTH-1];
                    cnt_d   = CW'(WIDTH);
                    state_d = MUL;
`endif
                end else begin
                    prod_d  = alu_res;
                    bad_set = alu_bad;
                    state_d = DONE;
                end
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_comb begin
        opa_d     = opa_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        intr_en_d = intr_en_q;
        if (wr_en) begin
            case (S_addr)
                8'h00: opa_d     = S_din;
                8'h01: opb_d     = S_din;
                8'h02: opc_d     = S_din[3:0];
                8'h05: intr_en_d = S_din[0];
                default: ;
            endcase
        end
        ovf_d = clear ? 1'b0 : (ovf_q | push_ovf);
        udf_d = clear ? 1'b0 : (udf_q | pop_udf);
        bad_d = clear ? 1'b0 : (bad_q | bad_set);
        irq_d = intr_en_q & ~res_empty;

        inst_wp_d  = inst_wp_q;
        inst_rp_d  = inst_rp_q;
        inst_cnt_d = inst_cnt_q;
        res_wp_d   = res_wp_q;
        res_rp_d   = res_rp_q;
        res_cnt_d  = res_cnt_q;
        if (clear) begin
            inst_wp_d  = '0;
            inst_rp_d  = '0;
            inst_cnt_d = '0;
            res_wp_d   = '0;
            res_rp_d   = '0;
            res_cnt_d  = '0;
        end else begin
            if (push_ok)  inst_wp_d = inst_wp_q + IPW'(1);
            if (ctrl_pop) inst_rp_d = inst_rp_q + IPW'(1);
            inst_cnt_d = inst_cnt_q + {{IPW{1'b0}}, push_ok} - {{IPW{1'b0}}, ctrl_pop};
            if (res_push) res_wp_d = res_wp_q + RPW'(1);
            if (bus_pop)  res_rp_d = res_rp_q + RPW'(1);
            res_cnt_d = res_cnt_q + {{RPW{1'b0}}, res_push} - {{RPW{1'b0}}, bus_pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            intr_en_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            bad_q      <= 1'b0;
            irq_q      <= 1'b0;
            inst_wp_q  <= '0;
            inst_rp_q  <= '0;
            inst_cnt_q <= '0;
            res_wp_q   <= '0;
            res_rp_q   <= '0;
            res_cnt_q  <= '0;
            state_q    <= IDLE;
            wa_q       <= '0;
            wb_q       <= '0;
            wop_q      <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
`ifdef ALU_MUL_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            opc_q      <= opc_d;
            intr_en_q  <= intr_en_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            bad_q      <= bad_d;
            irq_q      <= irq_d;
            inst_wp_q  <= inst_wp_d;
            inst_rp_q  <= inst_rp_d;
            inst_cnt_q <= inst_cnt_d;
            res_wp_q   <= res_wp_d;
            res_rp_q   <= res_rp_d;
            res_cnt_q  <= res_cnt_d;
            state_q    <= state_d;
            wa_q       <= wa_d;
            wb_q       <= wb_d;
            wop_q      <= wop_d;
            prod_q     <= prod_d;
            cnt_q      <= cnt_d;
`ifdef ALU_MUL_SIGNED_EN
            neg_q      <= neg_d;
`endif
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (push_ok)  inst_mem[inst_wp_q] <= {opa_q, opb_q, opc_q};
        if (res_push) res_mem[res_wp_q]   <= res_val;
    end

    assign status = {bad_q, udf_q, ovf_q, res_empty, res_full, inst_empty, inst_full,
                     (state_q != IDLE)};

    always_comb begin
        S_dout = '0;
        if (rd_en) begin
            case (S_addr)
                8'h00: S_dout = opa_q;
                8'h01: S_dout = opb_q;
                8'h02: S_dout = WIDTH'(opc_q);
                8'h04: S_dout = WIDTH'(status);
                8'h05: S_dout = WIDTH'(intr_en_q);
                8'h06: S_dout = res_empty ? '0 : res_mem[res_rp_q][WIDTH-1:0];
                8'h07: S_dout = res_empty ? '0 : res_mem[res_rp_q][2*WIDTH-1:WIDTH];
                default: S_dout = '0;
            endcase
        end
    end

    assign m_interrupt = irq_q;
endmodule
